// File: rtl/rv32i_pkg.sv
// Package rv32i: shared RV32I types for the front end.
//   rv32i_inst_u  - 32-bit instruction word, viewable raw or as R-type fields
//   fetch_state_e - fetch unit state (RUN, FLUSH)
//   FETCH_DEPTH   - instruction buffer depth; 2 with RV32I_FETCH_PREFETCH_EN
//                   defined (prefetching, one instr/cycle), otherwise 1
//   FETCH_CNT_W   - width of the outstanding/discard counters
package rv32i;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32i_rtype_t;

  typedef union packed {
    logic [31:0]  raw;
    rv32i_rtype_t r;
  } rv32i_inst_u;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

`ifdef RV32I_FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  localparam int FETCH_CNT_W = 2;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order buffer of fetched instructions, each tagged with its PC.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop all entries (wins over write/read)
//   wr_en_i, wr_instr_i, wr_pc_i   push one entry
//   rd_en_i              pop the head entry
//   valid_o, instr_o, pc_o         head entry (storage is reset to 0, so the
//                                   head reads 0 after reset)
//   count_o              number of entries held
// A write and a pop may happen in the same cycle even when full.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  logic [31:0]                    wr_instr_i,
  input  logic [31:0]                    wr_pc_i,
  input  logic                           rd_en_i,
  output logic                           valid_o,
  output logic [31:0]                    instr_o,
  output logic [31:0]                    pc_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SLOTS = 1 << PTR_W;

  logic [31:0]      instr_mem_q [SLOTS];
  logic [31:0]      pc_mem_q    [SLOTS];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic full, wr_ok, rd_ok;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  // When full, a write is only legal alongside a pop of the head.
  assign rd_ok = rd_en_i & (cnt_q != '0);
  assign wr_ok = wr_en_i & (~full | rd_ok);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SLOTS; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) begin
        instr_mem_q[wr_ptr_q] <= wr_instr_i;
        pc_mem_q[wr_ptr_q]    <= wr_pc_i;
        wr_ptr_q              <= ptr_next(wr_ptr_q);
      end
      if (rd_ok) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      cnt_q <= cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign instr_o = instr_mem_q[rd_ptr_q];
  assign pc_o    = pc_mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch.sv
// fetch: RV32I instruction fetch unit.
// Configuration macro: RV32I_FETCH_PREFETCH_EN (buffer depth 2 and up to two
// outstanding requests when defined; depth 1 / one outstanding otherwise).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt        request channel; accepted on req&gnt
//   imem_rvalid/imem_rdata             in-order responses, >=1 cycle after grant
//   redirect/redirect_pc               flush and restart at a new PC
//   instr_valid/instr_ready/instr/instr_pc   decoder channel
//   dbg_state_o                        current FSM state (RUN/FLUSH)
// Handshakes: a transfer happens in a cycle where valid (req) and ready (gnt)
// are both high; the sender keeps its payload stable while valid is high and
// ready is low, except that redirect may change the fetch address and
// withdraw buffered instructions.
module fetch
  import rv32i::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output rv32i_inst_u  instr,
  output logic [31:0]  instr_pc,
  output fetch_state_e dbg_state_o
);

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            rsp_pc_q, rsp_pc_d;   // PC of the next kept response
  logic [FETCH_CNT_W-1:0] out_q, out_d;         // requests granted, not answered
  logic [FETCH_CNT_W-1:0] disc_q, disc_d;       // stale responses still to drop
  fetch_state_e           state_q, state_d;

  logic [$clog2(FETCH_DEPTH+1)-1:0] fifo_cnt;
  logic [31:0] fifo_instr;
  logic        gnt_fire, rsp_fire, pop_fire, buf_wr;
  logic [2:0]  used_c;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign gnt_fire = imem_req & imem_gnt;
  // A response with nothing outstanding belongs to a request from before
  // reset and is ignored.
  assign rsp_fire = imem_rvalid & (out_q != '0);
  assign pop_fire = instr_valid & instr_ready & ~redirect;
  assign buf_wr   = rsp_fire & (state_q == RUN) & ~redirect;

  // Slots already claimed: in flight plus buffered, minus the entry leaving
  // this cycle. Counting the pop lets the buffer stream at full rate.
  assign used_c   = {1'b0, out_q} + 3'(fifo_cnt) - {2'b00, pop_fire};
  assign imem_req = rst_n & (used_c < 3'(FETCH_DEPTH));
  assign imem_addr = pc_q;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    disc_d   = disc_q;
    state_d  = state_q;
    out_d    = out_q + {1'b0, gnt_fire} - {1'b0, rsp_fire};

    if (gnt_fire) pc_d = pc_q + 32'd4;
    if (buf_wr)   rsp_pc_d = rsp_pc_q + 32'd4;

    case (state_q)
      RUN: ;
      FLUSH: begin
        if (rsp_fire) begin
          disc_d = disc_q - FETCH_CNT_W'(1);
          if (disc_q == FETCH_CNT_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Everything still in flight after this cycle (including a grant made
    // now) belongs to the old path; a response arriving now is dropped too.
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rsp_pc_d = {redirect_pc[31:2], 2'b00};
      disc_d   = out_d;
      state_d  = (out_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      state_q  <= RUN;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      state_q  <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FETCH_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (redirect),
    .wr_en_i    (buf_wr),
    .wr_instr_i (imem_rdata),
    .wr_pc_i    (rsp_pc_q),
    .rd_en_i    (pop_fire),
    .valid_o    (instr_valid),
    .instr_o    (fifo_instr),
    .pc_o       (instr_pc),
    .count_o    (fifo_cnt)
  );

  assign instr       = rv32i_inst_u'(fifo_instr);
  assign dbg_state_o = state_q;

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_req, output, 1 bit: memory request valid.
REQ-005 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 SHALL have port imem_gnt, input, 1 bit: request accepted in the cycle imem_req&imem_gnt.
REQ-007 SHALL have port imem_rvalid, input, 1 bit: response data valid; responses return in request order, at least 1 cycle after grant.
REQ-008 SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-009 SHALL have port redirect, input, 1 bit: branch/jump taken; flush and restart.
REQ-010 SHALL have port redirect_pc, input, 32 bits: new fetch address.
REQ-011 SHALL have port instr_valid, output, 1 bit: instr/instr_pc valid toward the decoder.
REQ-012 SHALL have port instr_ready, input, 1 bit: decoder accepts in the cycle instr_valid&instr_ready.
REQ-013 SHALL have port instr, output, rv32i_inst_u (32 bits): instruction to the decoder.
REQ-014 SHALL have port instr_pc, output, 32 bits: address of instr.

Function
REQ-015 SHALL hold imem_addr and imem_req stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-016 SHALL advance the fetch PC by 4 on each grant; the 32-bit wrap from 32'hFFFF_FFFC to 32'h0 is legal.
REQ-017 SHALL maintain an outstanding-request counter: +1 on grant, -1 on rvalid, both in one cycle leaving it unchanged.
REQ-018 SHALL assert imem_req only when outstanding plus buffered entries is less than buffer depth, so a response is never dropped.
REQ-019 SHALL write every non-discarded rvalid response into an in-order buffer tagged with its PC; instr/instr_pc present the head entry.
REQ-020 SHALL permit a buffer write and a head pop in the same cycle when full, with no bubble.
REQ-021 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL, on redirect, in that same cycle: empty the buffer, deassert instr_valid in the next cycle, and load fetch PC with {redirect_pc[31:2],2'b00}.
REQ-023 SHALL, on redirect, record the outstanding count (excluding any rvalid in that cycle) as a discard count, and drop that many subsequent responses.
REQ-024 SHALL let redirect override a simultaneous grant and a simultaneous decoder pop; an address granted in the redirect cycle counts as outstanding and is discarded.
REQ-025 SHALL implement the state machine with states RUN (issuing/filling) and FLUSH (discard count > 0; no buffer writes, requests to the new PC permitted), returning FLUSH->RUN when the discard count reaches 0.

Reset
REQ-026 SHALL, while rst_n=0, force: fetch PC = RESET_PC; imem_req = 0; instr_valid = 0; instr = 0; instr_pc = 0; counters = 0; state RUN.
REQ-027 SHALL issue its first request in the first cycle after rst_n deasserts, discarding any in-flight memory response.

Configuration
REQ-028 SHALL, with RV32I_FETCH_PREFETCH_EN defined, use buffer depth 2 with up to 2 outstanding requests, sustaining one instruction per cycle with 1-cycle memory latency.
REQ-029 SHALL, without RV32I_FETCH_PREFETCH_EN, use buffer depth 1 with at most 1 outstanding request, giving at most one instruction every 2 cycles.

Structure
REQ-030 SHALL take rv32i_inst_u from package rv32i and add fetch_state_e (RUN, FLUSH) to that package.
REQ-031 SHALL place the PC-tagged buffer in sub-module fetch_fifo, parameterised by depth.

Verification
REQ-032 Reset: RESET_PC=32'h100, release rst_n, gnt=1 -> imem_addr 32'h100 then 32'h104; first instr_pc = 32'h100.
REQ-033 Back-pressure: instr_ready=0 for 5 cycles with macro set -> at most 2 buffered; instr stable; no requests beyond depth; no loss on release.
REQ-034 Redirect with 2 outstanding: redirect_pc=32'h203 -> next imem_addr 32'h200; the 2 stale responses are dropped; first instr_pc 32'h200.
REQ-035 Wrap: redirect to 32'hFFFF_FFFC -> subsequent fetches at 32'hFFFF_FFFC, then 32'h0000_0000.
REQ-036 Grant stall: imem_gnt=0 for 3 cycles -> imem_addr held; PC advances only on grant.
REQ-037 Mid-operation reset: assert rst_n=0 with data buffered -> instr_valid=0 immediately; restart at RESET_PC.
